serial_logic_unit: RTL
======================

SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operand request valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port op, input, 2 bits: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 The block SHALL have port result, output, WIDTH bits: bitwise op(a,b).
REQ-012 The block SHALL have port zero, output, 1 bit: result equals all-zeros, qualified by out_valid.

Function
REQ-013 The block SHALL implement the FSM states IDLE, RUN and DONE, and SHALL be in IDLE after reset.
REQ-014 The block SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE; both SHALL be combinational decodes of state.
REQ-015 In IDLE, when in_valid && in_ready at an edge, the block SHALL register a, b and op, clear the bit counter to 0, and enter RUN; with in_valid low it SHALL stay in IDLE.
REQ-016 In RUN, the block SHALL compute exactly one result bit per clock, LSB first: at the i-th edge after acceptance (i = 1..WIDTH) it SHALL compute bit i-1 from the registered operands and shift it into the result register.
REQ-017 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap; on the edge that computes bit WIDTH-1 the block SHALL enter DONE.
REQ-018 Latency: out_valid SHALL first be high in the cycle following the WIDTH-th edge after the accepting edge (WIDTH = 8 gives 8 edges).
REQ-019 In DONE, result and zero SHALL be held stable until out_valid && out_ready at an edge; the block SHALL then enter IDLE, with in_ready = 1 in the following cycle.
REQ-020 If out_ready is already high when DONE is entered, the transfer SHALL complete on the next edge (minimum one DONE cycle).
REQ-021 The block SHALL accept no new request while in RUN or DONE; in_valid, a, b and op SHALL be ignored in those states, and mid-operation input changes SHALL NOT affect the result.
REQ-022 The zero output SHALL be registered and updated on the DONE-entry edge; it SHALL read 0 whenever out_valid = 0.
REQ-023 The result SHALL keep its last completed value outside DONE; consumers SHALL qualify it with out_valid.
REQ-024 An undefined state encoding SHALL return the FSM to IDLE on the next edge.

Reset
REQ-025 When rst_n = 0, the block SHALL immediately (without waiting for clk) set state to IDLE and clear the counter, the operand registers, result and zero; out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-026 A reset asserted during RUN or DONE SHALL abort the operation with no result delivered; after rst_n rises, the first edge with in_valid = 1 SHALL start a fresh operation.

Verification (WIDTH = 8)
REQ-027 The bench SHALL cover: a = 8'hF0, b = 8'h3C, op = 00, out_ready = 1 -> out_valid high after 8 edges, result = 8'h30, zero = 0, in_ready high one cycle after the transfer.
REQ-028 The bench SHALL cover all ops with a = 8'hAA, b = 8'h55: 00 gives 8'h00 with zero = 1; 01 gives 8'hFF; 10 gives 8'hFF; 11 gives 8'hFF.
REQ-029 The bench SHALL cover backpressure: out_ready held low for 5 cycles after out_valid -> result and zero stable throughout and in_ready = 0; out_ready = 1 -> IDLE on the next edge.
REQ-030 The bench SHALL cover input disturbance: a, b, op and in_valid toggled randomly during RUN -> result equals op applied to the values captured at acceptance.
REQ-031 The bench SHALL cover mid-operation reset: rst_n pulsed low between clock edges 4 edges into RUN -> out_valid = 0, in_ready = 1 and result = 0 immediately; the next request completes correctly.
REQ-032 The bench SHALL cover back-to-back requests: in_valid held high with out_ready = 1 -> one accept every WIDTH+2 cycles, with no request lost or duplicated.

Source files
------------

// File: rtl/serial_logic_unit.sv
// Bit-serial bitwise logic unit: accepts one operand pair, produces the
// result one bit per clock (LSB first), then presents it with a
// valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; in_ready = 1
// RUN   | shifting out one result bit per clock from the captured operands
// DONE  | result presented; out_valid = 1 until out_ready is seen

module serial_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // One extra counter bit so the count can reach WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;

    logic             bit_c;
    logic [WIDTH-1:0] sh_next;

    // Current result bit: operands are shifted right each RUN cycle, so
    // bit 0 of the captured operands is always the bit being processed.
    always_comb begin
        bit_c = 1'b0;
        case (op_q)
            2'b00:   bit_c = a_q[0] & b_q[0];
            2'b01:   bit_c = a_q[0] | b_q[0];
            2'b10:   bit_c = a_q[0] ^ b_q[0];
            default: bit_c = ~(a_q[0] & b_q[0]);
        endcase
        sh_next = {bit_c, sh_q[WIDTH-1:1]};
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        sh_d    = sh_q;
        res_d   = res_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sh_d  = sh_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Result is only published here so it keeps the last
                    // completed value while a new operation runs.
                    res_d   = sh_next;
                    zero_d  = (sh_next == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            sh_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    // zero is only meaningful alongside a presented result.
    assign zero      = zero_q & out_valid;

endmodule
